cpu_mem_loader: RTL and testbench
=================================

Name: cpu_mem_loader

Overview:
- Host-side initiator for the cpu external memory ports.
- Streams a program image into instruction memory and an initial image into data memory through a valid/ready input stream.
- Then holds cpu enable high for a programmed number of cycles, reads a data-memory window back and streams it out through a valid/ready output stream.
- Sits between the testbench/host link and the cpu top; it is the only driver of addr_ext/wen_ext/ren_ext/wdata_ext, the *_2 equivalents and enable.

Parameters:
- DATA_W, 32, word width of the streams and memory ports.
- CNT_W, 16, width of all word/cycle counters.
- ADDR_STEP, 4, byte increment between consecutive words on addr_ext/addr_ext_2.
- RD_LAT, 1, cycles from ren_ext_2 sampled high to rdata_ext_2 valid.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; latches the cfg_* inputs and begins a session.
- cfg_imem_words  in  CNT_W  words to write into instruction memory, from address 0.
- cfg_dmem_words  in  CNT_W  words to write into data memory, from address 0.
- cfg_run_cycles  in  CNT_W  cycles to hold enable high.
- cfg_dump_base  in  DATA_W  byte address of the first data-memory word read back.
- cfg_dump_words  in  CNT_W  words read back.
- in_valid/in_ready  in/out  1  input stream handshake.
- in_data  in  DATA_W  image word.
- out_valid/out_ready  out/in  1  output stream handshake.
- out_data  out  DATA_W  read-back word.
- busy  out  1  session in progress.
- done  out  1  one-cycle pulse at session end.
- enable  out  1  cpu run enable.
- addr_ext, wen_ext, ren_ext, wdata_ext  out  DATA_W/1/1/DATA_W  instruction memory external port.
- addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2  out  DATA_W/1/1/DATA_W  data memory external port.
- rdata_ext_2  in  DATA_W  data memory read data.

Behaviour:
- Reset (synchronous):
  - State IDLE; all outputs 0, including enable, every wen/ren, in_ready, out_valid, busy and done.
  - All counters are cleared.
  - Reset asserted mid-session aborts the session the next edge; no partial write completes after the reset edge.
- States: IDLE, LOAD_I, LOAD_D, RUN, RD_REQ, RD_WAIT, RD_OUT, DONE.
- IDLE:
  - start latches cfg_*, sets busy and enters LOAD_I.
  - Stages with a zero count are skipped in order: LOAD_I, LOAD_D, RUN, RD_REQ, then DONE.
  - start is ignored while busy.
- LOAD_I:
  - in_ready=1.
  - On in_valid&in_ready: wen_ext=1 the same cycle, wdata_ext=in_data, addr_ext=idx*ADDR_STEP, then idx increments.
  - wen_ext is combinational on the handshake and is never high without a handshake.
  - After the cfg_imem_words-th write, the next cycle is LOAD_D with idx=0 and in_ready=0 for that transition cycle.
- LOAD_D: same rules on the *_2 port, using cfg_dmem_words.
- RUN:
  - enable=1 for exactly cfg_run_cycles consecutive cycles.
  - in_ready=0, and no ext strobes are asserted.
  - enable drops on the cycle the state leaves RUN.
- RD_REQ:
  - ren_ext_2=1 for one cycle with addr_ext_2=cfg_dump_base+idx*ADDR_STEP.
  - Moves to RD_WAIT, which lasts RD_LAT-1 cycles (zero when RD_LAT=1).
  - Then rdata_ext_2 is captured into out_data and the state moves to RD_OUT.
- RD_OUT:
  - out_valid=1 and out_data stays stable until out_ready.
  - On the handshake, idx increments; go to RD_REQ if words remain, else DONE.
  - out_valid never drops without a handshake.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Arithmetic:
  - Address = base + idx*ADDR_STEP, computed in DATA_W bits and wrapping modulo 2^DATA_W.
  - idx and cycle counters are CNT_W bits.
  - A count of 2^CNT_W-1 is legal.
- Only one ext port strobe is ever high in a given cycle; wen and ren are never high together.

Decomposition:
- Package cpu_loader_pkg holds the state enum encoding (3 bits) and ADDR_STEP/RD_LAT defaults.
- One natural sub-module, stream_hold_reg: a single-entry output register implementing the valid/ready hold rule for out_valid/out_data.

Test Plan:
- Load 3 imem words 0x20010005, 0x20020007, 0x00221820 with in_valid held high -> wen_ext high 3 consecutive cycles at addr 0x0, 0x4, 0x8; no wen_ext_2 asserted.
- imem=2, dmem=2 with in_valid toggling every other cycle -> exactly 4 writes, data in order, wen never high without a handshake.
- run_cycles=10 -> enable high exactly 10 cycles; no strobes during RUN; done pulses after the dump.
- Dump base 0x10, 2 words (memory holds 0xA, 0xB), out_ready low for 3 cycles -> out_data=0xA stays stable while out_valid is high, then 0xB; ren_ext_2 at 0x10 and 0x14 only.
- All counts 0 -> done pulses 2 cycles after start; no strobes and no enable.
- rst asserted mid-RUN (cycle 4 of 10) -> enable=0 and busy=0 the next cycle; a new start then runs a full session correctly.

Source files
------------

// File: rtl/cpu_loader_pkg.sv
// Shared definitions for the cpu memory loader: session state encoding,
// default parameter values and the stage-skipping rule.
package cpu_loader_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int CNT_W_DEF     = 16;
  localparam int ADDR_STEP_DEF = 4;
  localparam int RD_LAT_DEF    = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_I  = 3'd1,
    ST_LOAD_D  = 3'd2,
    ST_RUN     = 3'd3,
    ST_RD_REQ  = 3'd4,
    ST_RD_WAIT = 3'd5,
    ST_RD_OUT  = 3'd6,
    ST_DONE    = 3'd7
  } state_e;

  // Next stage after 'from' (LOAD_I, LOAD_D or RUN), skipping every later
  // stage whose programmed count is zero.
  function automatic state_e stage_after(input state_e from,
                                         input logic   dmem_nz,
                                         input logic   run_nz,
                                         input logic   dump_nz);
    state_e nxt;
    if (from == ST_LOAD_I && dmem_nz)                          nxt = ST_LOAD_D;
    else if ((from == ST_LOAD_I || from == ST_LOAD_D) && run_nz) nxt = ST_RUN;
    else if (dump_nz)                                          nxt = ST_RD_REQ;
    else                                                       nxt = ST_DONE;
    return nxt;
  endfunction

endpackage

// File: rtl/stream_hold_reg.sv
// Single-entry output register: once loaded, valid and data are held
// unchanged until the consumer accepts them with ready.
module stream_hold_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;

  // Next entry contents: a handshake empties it, a load fills it.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && out_ready) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end
  end

  // Entry register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: flops take non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/cpu_mem_loader.sv
// Host-side initiator for the cpu external memory ports: loads the
// instruction and data images, runs the cpu for a programmed number of
// cycles, then reads a data-memory window back out on a stream.
module cpu_mem_loader
  import cpu_loader_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int ADDR_STEP = ADDR_STEP_DEF,
  parameter int RD_LAT    = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_imem_words,
  input  logic [CNT_W-1:0]  cfg_dmem_words,
  input  logic [CNT_W-1:0]  cfg_run_cycles,
  input  logic [DATA_W-1:0] cfg_dump_base,
  input  logic [CNT_W-1:0]  cfg_dump_words,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              enable,
  output logic [DATA_W-1:0] addr_ext,
  output logic              wen_ext,
  output logic              ren_ext,
  output logic [DATA_W-1:0] wdata_ext,
  output logic [DATA_W-1:0] addr_ext_2,
  output logic              wen_ext_2,
  output logic              ren_ext_2,
  output logic [DATA_W-1:0] wdata_ext_2,
  input  logic [DATA_W-1:0] rdata_ext_2
);

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  // Last RD_WAIT count value; unused when the read latency is a single cycle.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  idx_q,   idx_d;      // word index within the current stage
  logic [CNT_W-1:0]  cyc_q,   cyc_d;      // cycle counter for RUN and RD_WAIT
  logic [CNT_W-1:0]  imem_q,  imem_d;
  logic [CNT_W-1:0]  dmem_q,  dmem_d;
  logic [CNT_W-1:0]  run_q,   run_d;
  logic [CNT_W-1:0]  dump_q,  dump_d;
  logic [DATA_W-1:0] base_q,  base_d;
  logic              settle_q, settle_d;  // bubble cycle on entry to LOAD_D after the last imem write
  logic              cap_q,    cap_d;     // read data is valid on rdata_ext_2 this cycle

  logic              imem_nz, dmem_nz, run_nz, dump_nz;
  logic              in_hs, out_hs, hold_valid;
  logic [DATA_W-1:0] offset;

  assign imem_nz = |imem_q;
  assign dmem_nz = |dmem_q;
  assign run_nz  = |run_q;
  assign dump_nz = |dump_q;

  // Byte offset of the current word; wraps modulo 2^DATA_W when added to the base.
  assign offset = DATA_W'(idx_q) * DATA_W'(ADDR_STEP);

  // Handshakes are qualified with rst so nothing is accepted or written on a reset cycle.
  assign in_ready  = ~rst & (((state_q == ST_LOAD_I) & imem_nz) |
                             ((state_q == ST_LOAD_D) & ~settle_q));
  assign in_hs     = in_valid & in_ready;
  assign out_valid = hold_valid & ~rst;
  assign out_hs    = out_valid & out_ready;

  stream_hold_reg #(.DATA_W(DATA_W)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (cap_q),
    .load_data (rdata_ext_2),
    .out_ready (out_ready),
    .out_valid (hold_valid),
    .out_data  (out_data)
  );

  // State register, counters and latched session configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cyc_q    <= '0;
      imem_q   <= '0;
      dmem_q   <= '0;
      run_q    <= '0;
      dump_q   <= '0;
      base_q   <= '0;
      settle_q <= 1'b0;
      cap_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cyc_q    <= cyc_d;
      imem_q   <= imem_d;
      dmem_q   <= dmem_d;
      run_q    <= run_d;
      dump_q   <= dump_d;
      base_q   <= base_d;
      settle_q <= settle_d;
      cap_q    <= cap_d;
    end
  end

  // Next-state logic: stage sequencing, word/cycle counting and skip of empty stages.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cyc_d    = cyc_q;
    imem_d   = imem_q;
    dmem_d   = dmem_q;
    run_d    = run_q;
    dump_d   = dump_q;
    base_d   = base_q;
    settle_d = 1'b0;
    cap_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          imem_d  = cfg_imem_words;
          dmem_d  = cfg_dmem_words;
          run_d   = cfg_run_cycles;
          dump_d  = cfg_dump_words;
          base_d  = cfg_dump_base;
          idx_d   = '0;
          cyc_d   = '0;
          state_d = ST_LOAD_I;
        end
      end
      ST_LOAD_I: begin
        if (!imem_nz) begin
          state_d = stage_after(ST_LOAD_I, dmem_nz, run_nz, dump_nz);
        end else if (in_hs) begin
          if (idx_q == imem_q - ONE) begin
            idx_d    = '0;
            state_d  = stage_after(ST_LOAD_I, dmem_nz, run_nz, dump_nz);
            settle_d = (state_d == ST_LOAD_D);
          end else begin
            idx_d = idx_q + ONE;
          end
        end
      end
      ST_LOAD_D: begin
        if (in_hs) begin
          if (idx_q == dmem_q - ONE) begin
            idx_d   = '0;
            state_d = stage_after(ST_LOAD_D, dmem_nz, run_nz, dump_nz);
          end else begin
            idx_d = idx_q + ONE;
          end
        end
      end
      ST_RUN: begin
        if (cyc_q == run_q - ONE) begin
          cyc_d   = '0;
          state_d = stage_after(ST_RUN, dmem_nz, run_nz, dump_nz);
        end else begin
          cyc_d = cyc_q + ONE;
        end
      end
      ST_RD_REQ: begin
        if (RD_LAT > 1) begin
          cyc_d   = '0;
          state_d = ST_RD_WAIT;
        end else begin
          cap_d   = 1'b1;
          state_d = ST_RD_OUT;
        end
      end
      ST_RD_WAIT: begin
        if (cyc_q == WAIT_LAST) begin
          cyc_d   = '0;
          cap_d   = 1'b1;
          state_d = ST_RD_OUT;
        end else begin
          cyc_d = cyc_q + ONE;
        end
      end
      ST_RD_OUT: begin
        if (out_hs) begin
          if (idx_q == dump_q - ONE) begin
            idx_d   = '0;
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + ONE;
            state_d = ST_RD_REQ;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: memory strobes, cpu enable and session status per state.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    enable      = 1'b0;
    addr_ext    = '0;
    wen_ext     = 1'b0;
    ren_ext     = 1'b0;
    wdata_ext   = '0;
    addr_ext_2  = '0;
    wen_ext_2   = 1'b0;
    ren_ext_2   = 1'b0;
    wdata_ext_2 = '0;
    if (!rst) begin
      busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
      unique case (state_q)
        ST_LOAD_I: begin
          addr_ext  = offset;
          wen_ext   = in_hs;
          wdata_ext = in_hs ? in_data : '0;
        end
        ST_LOAD_D: begin
          addr_ext_2  = offset;
          wen_ext_2   = in_hs;
          wdata_ext_2 = in_hs ? in_data : '0;
        end
        ST_RUN:    enable = 1'b1;
        ST_RD_REQ: begin
          ren_ext_2  = 1'b1;
          addr_ext_2 = base_q + offset;
        end
        ST_DONE:   done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_loader.sv
// Scoreboard bench for cpu_mem_loader: a reference model built from the
// loader's rules queues expected writes, read addresses and output words;
// a monitor pops and compares whenever the DUT presents a strobe or word.
module tb_cpu_mem_loader;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              rst;
  logic              start;
  logic [CNT_W-1:0]  cfg_imem_words, cfg_dmem_words, cfg_run_cycles, cfg_dump_words;
  logic [DATA_W-1:0] cfg_dump_base;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy, done, enable;
  logic [DATA_W-1:0] addr_ext, wdata_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
  logic              wen_ext, ren_ext, wen_ext_2, ren_ext_2;

  cpu_mem_loader #(.DATA_W(DATA_W), .CNT_W(CNT_W), .ADDR_STEP(4), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_imem_words(cfg_imem_words), .cfg_dmem_words(cfg_dmem_words),
    .cfg_run_cycles(cfg_run_cycles), .cfg_dump_base(cfg_dump_base),
    .cfg_dump_words(cfg_dump_words),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .enable(enable),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  // Scoreboard queues and stimulus images.
  wr_t         exp_iw[$], exp_dw[$];
  logic [31:0] exp_rd[$], exp_out[$], feed_q[$];
  logic [31:0] img_i[$], img_d[$];

  // dmem_m is the live data memory the DUT talks to; ref_mem is the model's view.
  logic [31:0] dmem_m  [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] preset(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return dmem_m.exists(a) ? dmem_m[a] : preset(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : preset(a);
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-session observation state.
  int          en_cnt, en_rises, viol, iw_n, iw_first, iw_last, vcnt;
  int          start_cyc, done_cyc;
  bit          done_seen;
  bit          prev_en, prev_v, prev_r;
  logic [31:0] prev_d;
  wr_t         e_w;
  logic [31:0] e_a;
  logic [31:0] rd_pending;
  bit          rd_fire = 1'b0;
  int          in_mode = 0;     // 0 hold valid, 1 alternate, 2 random
  int          ready_mode = 2;  // 0 random, 1 stall 3 cycles, 2 always ready

  // Monitor: pops and compares on every strobe / output handshake, tracks protocol rules.
  always @(negedge clk) begin
    if (rst) begin
      prev_en = 1'b0; prev_v = 1'b0; prev_r = 1'b0; vcnt = 0;
    end else begin
      if (wen_ext) begin
        if (exp_iw.size() == 0) check(1'b0, "imem_unexpected_write", {addr_ext, wdata_ext}, 0);
        else begin
          e_w = exp_iw.pop_front();
          check(addr_ext == e_w.addr && wdata_ext == e_w.data, "imem_write",
                {addr_ext, wdata_ext}, e_w);
        end
        if (iw_n == 0) iw_first = cyc;
        iw_last = cyc;
        iw_n++;
      end
      if (wen_ext_2) begin
        if (exp_dw.size() == 0) check(1'b0, "dmem_unexpected_write", {addr_ext_2, wdata_ext_2}, 0);
        else begin
          e_w = exp_dw.pop_front();
          check(addr_ext_2 == e_w.addr && wdata_ext_2 == e_w.data, "dmem_write",
                {addr_ext_2, wdata_ext_2}, e_w);
        end
        dmem_m[addr_ext_2] = wdata_ext_2;
      end
      if (ren_ext_2) begin
        if (exp_rd.size() == 0) check(1'b0, "dmem_unexpected_read", addr_ext_2, 0);
        else begin
          e_a = exp_rd.pop_front();
          check(addr_ext_2 == e_a, "dmem_read_addr", addr_ext_2, e_a);
        end
        rd_pending = mem_rd(addr_ext_2);
        rd_fire    = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) check(1'b0, "out_unexpected_word", out_data, 0);
        else begin
          e_a = exp_out.pop_front();
          check(out_data == e_a, "out_word", out_data, e_a);
        end
      end
      if (wen_ext && !(in_valid && in_ready)) viol++;
      if (wen_ext_2 && !(in_valid && in_ready)) viol++;
      if (int'(wen_ext) + int'(ren_ext) + int'(wen_ext_2) + int'(ren_ext_2) > 1) viol++;
      if (enable && (wen_ext || ren_ext || wen_ext_2 || ren_ext_2 || in_ready)) viol++;
      if (ren_ext) viol++;
      if (!busy && (in_ready || enable || out_valid)) viol++;
      if (prev_v && !prev_r && (!out_valid || out_data != prev_d)) viol++;
      if (enable) en_cnt++;
      if (enable && !prev_en) en_rises++;
      if (done) begin done_seen = 1'b1; done_cyc = cyc; end
      if (out_valid && out_ready) vcnt = 0;
      else if (out_valid) vcnt++;
      prev_en = enable; prev_v = out_valid; prev_r = out_ready; prev_d = out_data;
    end
  end

  // Data memory read port: one cycle latency, random garbage otherwise.
  always @(posedge clk) begin
    #1;
    if (rd_fire) begin
      rdata_ext_2 = rd_pending;
      rd_fire     = 1'b0;
    end else begin
      rdata_ext_2 = $urandom;
    end
  end

  // Output consumer.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'($urandom_range(0, 1));
      1:       out_ready = (vcnt >= 3);
      default: out_ready = 1'b1;
    endcase
  end

  // Image feeder: presents feed_q words, pops one per observed handshake.
  initial begin
    bit hs_seen = 1'b0;
    bit phase   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (hs_seen && feed_q.size() > 0) void'(feed_q.pop_front());
      phase = ~phase;
      if (feed_q.size() > 0 &&
          (in_mode == 0 || (in_mode == 1 && phase) || (in_mode == 2 && $urandom_range(0, 1) == 1))) begin
        in_valid = 1'b1;
        in_data  = feed_q[0];
      end else begin
        in_valid = 1'b0;
        in_data  = $urandom;
      end
      @(negedge clk);
      hs_seen = in_valid && in_ready;
    end
  end

  // Build expectations from the images, then pulse start with the session config.
  task automatic start_session(input int nr, input logic [31:0] base, input int nw,
                               input int imode, input int rmode);
    logic [31:0] a;
    for (int k = 0; k < img_i.size(); k++) begin
      exp_iw.push_back(wr_t'{addr: 32'(k) * 32'd4, data: img_i[k]});
      feed_q.push_back(img_i[k]);
    end
    for (int k = 0; k < img_d.size(); k++) begin
      a = 32'(k) * 32'd4;
      exp_dw.push_back(wr_t'{addr: a, data: img_d[k]});
      ref_mem[a] = img_d[k];
      feed_q.push_back(img_d[k]);
    end
    for (int k = 0; k < nw; k++) begin
      a = base + 32'(k) * 32'd4;
      exp_rd.push_back(a);
      exp_out.push_back(ref_rd(a));
    end
    en_cnt = 0; en_rises = 0; viol = 0; iw_n = 0; done_seen = 1'b0;
    in_mode = imode; ready_mode = rmode;
    @(posedge clk); #1;
    start          = 1'b1;
    cfg_imem_words = 16'(img_i.size());
    cfg_dmem_words = 16'(img_d.size());
    cfg_run_cycles = 16'(nr);
    cfg_dump_base  = base;
    cfg_dump_words = 16'(nw);
    start_cyc      = cyc;
    @(posedge clk); #1;
    start          = 1'b0;
    cfg_imem_words = 16'($urandom);
    cfg_dmem_words = 16'($urandom);
    cfg_run_cycles = 16'($urandom);
    cfg_dump_base  = $urandom;
    cfg_dump_words = 16'($urandom);
    @(negedge clk);
    check(busy == 1'b1, "busy_after_start", busy, 1);
  endtask

  // Wait (bounded) for done, then confirm every expected event was consumed.
  task automatic finish_session(input string name, input int nr);
    int k = 0;
    while (!done_seen && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(done_seen, {name, "_done"}, done_seen, 1);
    repeat (2) @(negedge clk);
    check(exp_iw.size() == 0,  {name, "_imem_left"}, exp_iw.size(), 0);
    check(exp_dw.size() == 0,  {name, "_dmem_left"}, exp_dw.size(), 0);
    check(exp_rd.size() == 0,  {name, "_reads_left"}, exp_rd.size(), 0);
    check(exp_out.size() == 0, {name, "_out_left"}, exp_out.size(), 0);
    check(feed_q.size() == 0,  {name, "_feed_left"}, feed_q.size(), 0);
    check(en_cnt == nr,        {name, "_enable_cycles"}, en_cnt, nr);
    check(en_rises == ((nr > 0) ? 1 : 0), {name, "_enable_runs"}, en_rises, (nr > 0) ? 1 : 0);
    check(viol == 0,           {name, "_protocol"}, viol, 0);
    check(!busy && !enable,    {name, "_idle"}, {busy, enable}, 0);
    exp_iw.delete(); exp_dw.delete(); exp_rd.delete(); exp_out.delete(); feed_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1; start = 1'b0;
    cfg_imem_words = '0; cfg_dmem_words = '0; cfg_run_cycles = '0;
    cfg_dump_base = '0; cfg_dump_words = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(!in_ready && !out_valid && !busy && !done && !enable, "reset_status",
          {in_ready, out_valid, busy, done, enable}, 0);
    check(!wen_ext && !ren_ext && !wen_ext_2 && !ren_ext_2, "reset_strobes",
          {wen_ext, ren_ext, wen_ext_2, ren_ext_2}, 0);
    check(out_data == 0, "reset_out_data", out_data, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check(!busy && !in_ready, "idle_after_reset", {busy, in_ready}, 0);

    // Three imem words with valid held high: consecutive writes at 0, 4, 8.
    img_i = '{32'h2001_0005, 32'h2002_0007, 32'h0022_1820}; img_d = {};
    start_session(0, 32'h0, 0, 0, 2);
    finish_session("imem3", 0);
    check(iw_n == 3, "imem3_write_count", iw_n, 3);
    check(iw_last - iw_first == 2, "imem3_consecutive", iw_last - iw_first, 2);

    // Two + two words with valid toggling.
    img_i = '{32'h1111_0001, 32'h1111_0002}; img_d = '{32'h2222_0001, 32'h2222_0002};
    start_session(0, 32'h0, 0, 1, 2);
    finish_session("toggle", 0);

    // Run for 10 cycles then dump one word.
    img_i = '{32'hAAAA_0001}; img_d = '{32'hBBBB_0001};
    start_session(10, 32'h0, 1, 0, 0);
    finish_session("run10", 10);

    // Dump of two preset words with a 3-cycle consumer stall.
    dmem_m[32'h10] = 32'hA; ref_mem[32'h10] = 32'hA;
    dmem_m[32'h14] = 32'hB; ref_mem[32'h14] = 32'hB;
    img_i = {}; img_d = {};
    start_session(0, 32'h10, 2, 0, 1);
    finish_session("dump_stall", 0);

    // All counts zero: done two cycles after start.
    img_i = {}; img_d = {};
    start_session(0, 32'h0, 0, 0, 2);
    finish_session("all_zero", 0);
    check(done_cyc - start_cyc == 2, "all_zero_latency", done_cyc - start_cyc, 2);

    // Reset in the middle of RUN, then a full session.
    img_i = '{32'hC0DE_0001, 32'hC0DE_0002}; img_d = '{32'hD00D_0001};
    start_session(10, 32'h0, 2, 0, 2);
    k = 0;
    while (en_cnt < 4 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check(en_cnt == 4, "rst_reached_run", en_cnt, 4);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check(!enable && !busy, "rst_cycle_outputs", {enable, busy}, 0);
    @(posedge clk); #1; rst = 1'b0;
    exp_iw.delete(); exp_dw.delete(); exp_rd.delete(); exp_out.delete(); feed_q.delete();
    @(negedge clk);
    check(!enable && !busy && !in_ready, "after_rst_idle", {enable, busy, in_ready}, 0);
    check(!done_seen, "rst_no_done", done_seen, 0);
    img_i = '{32'h0BAD_0001}; img_d = '{32'h0BAD_1001, 32'h0BAD_1002};
    start_session(5, 32'h0, 2, 2, 0);
    finish_session("after_rst", 5);

    // Randomized sessions, one with a dump window wrapping past 2^32.
    for (int s = 0; s < 6; s++) begin
      int          nr, nw;
      logic [31:0] base;
      img_i = {}; img_d = {};
      for (int j = $urandom_range(0, 4); j > 0; j--) img_i.push_back($urandom);
      for (int j = $urandom_range(0, 4); j > 0; j--) img_d.push_back($urandom);
      nr   = $urandom_range(0, 6);
      nw   = $urandom_range(0, 3);
      base = (s == 2) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_00FC);
      if (s == 2) nw = 4;
      start_session(nr, base, nw, $urandom_range(0, 2), $urandom_range(0, 1));
      finish_session($sformatf("rand%0d", s), nr);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
